// File: rtl/axi_wr_seq_pkg.sv
// Shared types and constants for the AXI write-burst sequencer.
// Holds the FSM state encoding, AXI burst/response codes and the B-response merge rule.
package axi_wr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The first non-OKAY response of a command sticks; later ones are ignored.
    function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] resp);
        return (acc == RESP_OKAY) ? resp : acc;
    endfunction

endpackage

// File: rtl/axi_wr_seq_burst_calc.sv
// Combinational burst sizing: picks the next burst length from the remaining beats,
// the per-burst cap and the distance to the next 4KB boundary.
module axi_wr_seq_burst_calc #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int REM_WIDTH  = 9,
    parameter int LEN_WIDTH  = 9
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [REM_WIDTH-1:0]  i_rem,
    output logic [LEN_WIDTH-1:0]  o_len,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic [REM_WIDTH-1:0]  o_next_rem
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int CW    = (REM_WIDTH > 13) ? REM_WIDTH : 13;

    logic [12:0]   w_room_bytes;
    logic [CW-1:0] w_room_beats;
    logic [CW-1:0] w_rem_ext;
    logic [CW-1:0] w_min;

    always_comb begin
        w_room_bytes = 13'd4096 - {1'b0, i_addr[11:0]};
        w_room_beats = CW'(w_room_bytes >> SIZE);
        w_rem_ext    = CW'(i_rem);
        w_min        = (w_rem_ext < CW'(MAX_BEATS)) ? w_rem_ext : CW'(MAX_BEATS);
        if (w_room_beats < w_min) begin
            w_min = w_room_beats;
        end
    end

    // The minimum never exceeds MAX_BEATS (<= 256), so it always fits LEN_WIDTH.
    assign o_len       = LEN_WIDTH'(w_min);
    assign o_next_addr = i_addr + (ADDR_WIDTH'(o_len) << SIZE);
    assign o_next_rem  = i_rem - REM_WIDTH'(o_len);

endmodule

// File: rtl/axi_wr_burst_seq.sv
// AXI write-burst sequencer: splits one command into legal INCR bursts, one outstanding,
// and merges all B responses into a single completion. Optional B timeout: AXI_WR_SEQ_BTIMEOUT_EN.
module axi_wr_burst_seq
    import axi_wr_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MAX_BEATS      = 16,
    parameter int CMD_LEN_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [CMD_LEN_WIDTH-1:0] cmd_beats,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    done_err,
    output logic                    done_timeout,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE      = $clog2(BYTES);
    localparam int REM_WIDTH = CMD_LEN_WIDTH + 1;
    localparam int LEN_WIDTH = 9;
    localparam int EW        = ADDR_WIDTH + REM_WIDTH + SIZE + 1;

    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || MAX_BEATS < 1 ||
        MAX_BEATS > 256 || TIMEOUT_CYCLES < 1 || ADDR_WIDTH < 12) begin : g_param_err
        $error("axi_wr_burst_seq: illegal parameter set");
    end

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [REM_WIDTH-1:0]   r_rem;
    logic [ID_WIDTH-1:0]    r_id;
    logic [1:0]             r_resp;
    logic                   r_err;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_beat;

    logic [LEN_WIDTH-1:0]   w_len;
    logic [ADDR_WIDTH-1:0]  w_next_addr;
    logic [REM_WIDTH-1:0]   w_next_rem;
    logic                   w_st_w;
    logic                   w_last;

`ifdef AXI_WR_SEQ_BTIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          r_tcnt;
    logic                   r_timeout;
`endif

    axi_wr_seq_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BEATS  (MAX_BEATS),
        .REM_WIDTH  (REM_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_calc (
        .i_addr      (r_addr),
        .i_rem       (r_rem),
        .o_len       (w_len),
        .o_next_addr (w_next_addr),
        .o_next_rem  (w_next_rem)
    );

    assign w_st_w = (r_state == ST_W);
    assign w_last = (r_beat == r_len - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_id    <= '0;
            r_resp  <= RESP_OKAY;
            r_err   <= 1'b0;
            r_len   <= '0;
            r_beat  <= '0;
`ifdef AXI_WR_SEQ_BTIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_rem   <= {1'b0, cmd_beats} + REM_WIDTH'(1);
                        r_id    <= cmd_id;
                        r_resp  <= RESP_OKAY;
                        r_err   <= 1'b0;
`ifdef AXI_WR_SEQ_BTIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_len   <= w_len;
                    r_beat  <= '0;
`ifdef AXI_WR_SEQ_BTIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                    r_state <= ST_AW;
                end
                ST_AW: begin
                    if (awready) begin
                        r_state <= ST_W;
                    end
                end
                ST_W: begin
                    if (wd_valid && wready) begin
                        r_beat <= r_beat + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    // Address/remaining advance only once the burst is acknowledged.
                    if (bvalid) begin
                        r_resp  <= resp_merge(r_resp, bresp);
                        r_err   <= r_err | (bid != r_id);
                        r_addr  <= w_next_addr;
                        r_rem   <= w_next_rem;
                        r_state <= (w_next_rem == '0) ? ST_DONE : ST_CALC;
                    end
`ifdef AXI_WR_SEQ_BTIMEOUT_EN
                    else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_resp    <= RESP_SLVERR;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign bready    = ((r_state == ST_IDLE) || (r_state == ST_B)) && !rst;

    assign awvalid = (r_state == ST_AW);
    assign awaddr  = awvalid ? r_addr : '0;
    assign awid    = awvalid ? r_id : '0;
    assign awlen   = awvalid ? 8'(r_len - LEN_WIDTH'(1)) : 8'd0;
    assign awsize  = awvalid ? 3'(SIZE) : 3'd0;
    assign awburst = awvalid ? AXI_BURST_INCR : 2'b00;

    assign wvalid   = w_st_w && wd_valid;
    assign wd_ready = w_st_w && wready;
    assign wdata    = w_st_w ? wd_data : '0;
    assign wstrb    = w_st_w ? wd_strb : '0;
    assign wlast    = w_st_w && w_last;

    assign done_valid = (r_state == ST_DONE);
    assign done_resp  = done_valid ? r_resp : RESP_OKAY;
    assign done_err   = done_valid && r_err;
`ifdef AXI_WR_SEQ_BTIMEOUT_EN
    assign done_timeout = done_valid && r_timeout;
`else
    assign done_timeout = 1'b0;
`endif

    // One extra bit above the address width exposes a wrap past the top of memory.
    logic [EW-1:0] w_cmd_end;
    assign w_cmd_end = EW'(cmd_addr) + ((EW'(cmd_beats) + EW'(1)) << SIZE);

    a_cmd_aligned: assert property (@(posedge clk) disable iff (rst)
        (cmd_valid && cmd_ready) |-> ((cmd_addr & ADDR_WIDTH'(BYTES - 1)) == '0));
    a_cmd_no_wrap: assert property (@(posedge clk) disable iff (rst)
        (cmd_valid && cmd_ready) |-> (w_cmd_end <= (EW'(1) << ADDR_WIDTH)));

endmodule

// File: tb/tb_axi_wr_burst_seq.sv
// Self-checking bench for axi_wr_burst_seq: directed vector table, reset and timeout
// sequences, and randomized commands checked against a burst-splitting reference model.
module tb_axi_wr_burst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_beats;
    logic [3:0]  cmd_id;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        done_valid, done_err, done_timeout;
    logic [1:0]  done_resp;
    logic        awvalid, awready;
    logic [15:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    axi_wr_burst_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .done_timeout(done_timeout),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    typedef struct {
        int addr;
        int beats;
    } burst_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  beats;
        logic [3:0]  id;
        bit          stl;
        int          badi;
        logic [1:0]  r0, r1, r2;
        int          nb;
        logic [7:0]  len0;
        logic [15:0] last_addr;
        logic [7:0]  last_len;
        logic [1:0]  resp;
        bit          err;
    } tv_t;

    burst_t      exp_aw[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_strb[$];
    bit          exp_last[$];
    logic [1:0]  bresp_cfg[$];
    logic [15:0] aw_log_addr[$];
    logic [7:0]  aw_log_len[$];

    int          checks = 0;
    int          errors = 0;
    bit          act, stall, no_b;
    int          bad_bid_idx;
    logic [3:0]  cur_id;
    int          aw_seen, w_seen, b_issued, b_pend, done_seen, wd_idx;
    logic [1:0]  cap_resp;
    logic        cap_err, cap_to;
    bit          aw_hold, w_hold, wd_hold, b_hold;
    logic [15:0] h_awaddr;
    logic [7:0]  h_awlen;
    logic [3:0]  h_awid;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic        h_wlast;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: greedy split by remaining beats, 16-beat cap and 4KB boundary.
    task automatic build_model(input int addr, input int beats);
        int rem, a, room, n;
        exp_aw.delete(); exp_data.delete(); exp_strb.delete(); exp_last.delete();
        rem = beats;
        a   = addr;
        while (rem > 0) begin
            room = (4096 - (a % 4096)) / 4;
            n = rem;
            if (n > 16)   n = 16;
            if (n > room) n = room;
            exp_aw.push_back('{addr: a, beats: n});
            for (int k = 0; k < n; k++) begin
                exp_data.push_back($urandom);
                exp_strb.push_back(4'($urandom));
                exp_last.push_back(k == n - 1);
            end
            a   = (a + n * 4) % 65536;
            rem = rem - n;
        end
    endtask

    // Per-cycle slave/source driver plus protocol monitor.
    task automatic step();
        @(negedge clk);
        if (!act) begin
            awready = 1'b0; wready = 1'b0; wd_valid = 1'b0; bvalid = 1'b0;
            aw_hold = 1'b0; w_hold = 1'b0; wd_hold = 1'b0; b_hold = 1'b0;
        end else begin
            awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!wd_hold) begin
                if (wd_idx < exp_data.size() && (!stall || $urandom_range(0, 1) == 1)) begin
                    wd_valid = 1'b1;
                    wd_data  = exp_data[wd_idx];
                    wd_strb  = exp_strb[wd_idx];
                end else begin
                    wd_valid = 1'b0;
                    wd_data  = $urandom;
                    wd_strb  = 4'($urandom);
                end
            end
            if (!b_hold) begin
                if (b_pend > 0 && !no_b && (!stall || $urandom_range(0, 2) == 0)) begin
                    bvalid = 1'b1;
                    bresp  = (b_issued < bresp_cfg.size()) ? bresp_cfg[b_issued] : 2'b00;
                    bid    = (b_issued == bad_bid_idx) ? (cur_id ^ 4'h1) : cur_id;
                end else begin
                    bvalid = 1'b0;
                end
            end
        end
        #1;
        if (act) begin
            if (aw_hold)
                chk("aw_stable", {awvalid, awid, awlen, awaddr}, {1'b1, h_awid, h_awlen, h_awaddr});
            if (awvalid && awready) begin
                if (aw_seen < exp_aw.size()) begin
                    chk("awaddr", awaddr, exp_aw[aw_seen].addr);
                    chk("awlen", awlen, exp_aw[aw_seen].beats - 1);
                    chk("awid", awid, cur_id);
                    chk("awsize", awsize, 2);
                    chk("awburst", awburst, 1);
                end else begin
                    chk("aw_extra", aw_seen, exp_aw.size());
                end
                aw_log_addr.push_back(awaddr);
                aw_log_len.push_back(awlen);
                aw_seen++;
            end
            aw_hold = awvalid && !awready;
            h_awaddr = awaddr; h_awlen = awlen; h_awid = awid;

            if (w_hold)
                chk("w_stable", {wvalid, wlast, wstrb, wdata}, {1'b1, h_wlast, h_wstrb, h_wdata});
            if (wvalid && wready) begin
                chk("wd_ready", wd_ready, 1);
                if (w_seen < exp_data.size()) begin
                    chk("wdata", wdata, exp_data[w_seen]);
                    chk("wstrb", wstrb, exp_strb[w_seen]);
                    chk("wlast", wlast, exp_last[w_seen]);
                end else begin
                    chk("w_extra", w_seen, exp_data.size());
                end
                if (wlast) b_pend++;
                w_seen++;
            end else if (wd_valid && wd_ready) begin
                chk("wd_hs_without_w", {wvalid, wready}, 2'b11);
            end
            if (wd_valid && wd_ready) wd_idx++;
            wd_hold = wd_valid && !wd_ready;
            w_hold  = wvalid && !wready;
            h_wdata = wdata; h_wstrb = wstrb; h_wlast = wlast;

            if (bvalid && bready) begin
                b_pend--;
                b_issued++;
            end
            b_hold = bvalid && !bready;

            if (done_valid) begin
                done_seen++;
                cap_resp = done_resp;
                cap_err  = done_err;
                cap_to   = done_timeout;
            end
        end
    endtask

    initial forever step();

    task automatic start_cmd(input logic [15:0] addr, input logic [7:0] beats, input logic [3:0] id,
                             input bit stl, input int badi, input logic [1:0] r0, input logic [1:0] r1,
                             input logic [1:0] r2, input bit rnd_resp);
        bit ok;
        build_model(int'(addr), int'(beats) + 1);
        bresp_cfg.delete();
        for (int k = 0; k < exp_aw.size(); k++) begin
            if (rnd_resp)
                bresp_cfg.push_back(($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            else
                bresp_cfg.push_back(k == 0 ? r0 : (k == 1 ? r1 : (k == 2 ? r2 : 2'b00)));
        end
        aw_log_addr.delete(); aw_log_len.delete();
        aw_seen = 0; w_seen = 0; b_issued = 0; b_pend = 0; done_seen = 0; wd_idx = 0;
        cur_id = id; stall = stl; bad_bid_idx = badi;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = beats; cmd_id = id;
        act = 1'b1;
        #2;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        if (!ok) chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
        #2;
        chk("awvalid_in_calc", awvalid, 0);
        @(negedge clk);
        #2;
        chk("awvalid_latency", awvalid, 1);
    endtask

    task automatic finish_cmd(input bit exp_to);
        logic [1:0] er;
        bit         ee;
        for (int t = 0; t < 20000 && done_seen == 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
        er = 2'b00;
        foreach (bresp_cfg[k]) begin
            if (bresp_cfg[k] != 2'b00) begin
                er = bresp_cfg[k];
                break;
            end
        end
        ee = (bad_bid_idx >= 0) && (bad_bid_idx < exp_aw.size());
        if (exp_to) begin
            er = 2'b10;
            ee = 1'b0;
        end
        chk("done_count", done_seen, 1);
        chk("done_resp", cap_resp, er);
        chk("done_err", cap_err, ee);
        chk("done_timeout", cap_to, exp_to);
        if (!exp_to) begin
            chk("aw_count", aw_seen, exp_aw.size());
            chk("w_count", w_seen, exp_data.size());
            chk("b_count", b_issued, exp_aw.size());
        end
        act = 1'b0;
        $display("txn id=%0h bursts=%0d beats=%0d resp=%0d err=%0d timeout=%0d",
                 cur_id, aw_seen, w_seen, cap_resp, cap_err, cap_to);
    endtask

    tv_t tv[7];

    initial begin
        rst = 1'b1; act = 1'b0; stall = 1'b0; no_b = 1'b0; bad_bid_idx = -1; cur_id = '0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;

        //        addr     beats id stl badi r0 r1 r2  nb len0  last_addr last_len resp err
        tv[0] = '{16'h0000, 8'd3,  4'h5, 0, -1, 0, 0, 0, 1, 8'd3,  16'h0000, 8'd3,  2'd0, 0};
        tv[1] = '{16'h0FF8, 8'd7,  4'h2, 0, -1, 0, 0, 0, 2, 8'd1,  16'h1000, 8'd5,  2'd0, 0};
        tv[2] = '{16'h0000, 8'd39, 4'h7, 0, -1, 0, 0, 0, 3, 8'd15, 16'h0080, 8'd7,  2'd0, 0};
        tv[3] = '{16'h0FF0, 8'd19, 4'h9, 1, -1, 0, 0, 0, 2, 8'd3,  16'h1000, 8'd15, 2'd0, 0};
        tv[4] = '{16'h0100, 8'd39, 4'h1, 0, -1, 0, 3, 2, 3, 8'd15, 16'h0180, 8'd7,  2'd3, 0};
        tv[5] = '{16'h0200, 8'd3,  4'h6, 0,  0, 0, 0, 0, 1, 8'd3,  16'h0200, 8'd3,  2'd0, 1};
        tv[6] = '{16'h03FC, 8'd0,  4'h4, 1, -1, 0, 0, 0, 1, 8'd0,  16'h03FC, 8'd0,  2'd0, 0};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_awsize", awsize, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_done", {done_valid, done_resp, done_err, done_timeout}, 0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_bready", bready, 1);

        for (int i = 0; i < 7; i++) begin
            start_cmd(tv[i].addr, tv[i].beats, tv[i].id, tv[i].stl, tv[i].badi,
                      tv[i].r0, tv[i].r1, tv[i].r2, 1'b0);
            finish_cmd(1'b0);
            chk("tv_nbursts", aw_log_addr.size(), tv[i].nb);
            if (aw_log_addr.size() > 0) begin
                chk("tv_len0", aw_log_len[0], tv[i].len0);
                chk("tv_last_addr", aw_log_addr[aw_log_addr.size() - 1], tv[i].last_addr);
                chk("tv_last_len", aw_log_len[aw_log_len.size() - 1], tv[i].last_len);
            end
            chk("tv_resp", cap_resp, tv[i].resp);
            chk("tv_err", cap_err, tv[i].err);
        end

        // Reset mid-burst, then a clean command to confirm recovery.
        start_cmd(16'h0000, 8'd15, 4'h3, 1'b0, -1, 2'd0, 2'd0, 2'd0, 1'b0);
        for (int t = 0; t < 200 && w_seen < 3; t++) @(negedge clk);
        chk("mid_burst_in_w", (w_seen >= 3 && w_seen < 16), 1);
        @(negedge clk);
        rst = 1'b1;
        act = 1'b0;
        @(negedge clk);
        #2;
        chk("midrst_awvalid", awvalid, 0);
        chk("midrst_wvalid", wvalid, 0);
        chk("midrst_done", done_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_valids", {awvalid, wvalid, done_valid}, 0);
        $display("txn reset mid-burst after %0d beats", w_seen);
        start_cmd(16'h2000, 8'd5, 4'hA, 1'b0, -1, 2'd0, 2'd0, 2'd0, 1'b0);
        finish_cmd(1'b0);

        for (int i = 0; i < 30; i++) begin
            int beats, bytes, addr, badi;
            beats = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 47);
            bytes = (beats + 1) * 4;
            if ($urandom_range(0, 1) == 1)
                addr = $urandom_range(1, 15) * 4096 - $urandom_range(0, 32) * 4;
            else
                addr = $urandom_range(0, 16383) * 4;
            if (addr + bytes > 65536) addr = 65536 - bytes;
            badi = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1;
            start_cmd(16'(addr), 8'(beats), 4'($urandom), 1'($urandom_range(0, 1)), badi,
                      2'd0, 2'd0, 2'd0, 1'b1);
            finish_cmd(1'b0);
        end

`ifdef AXI_WR_SEQ_BTIMEOUT_EN
        no_b = 1'b1;
        start_cmd(16'h0400, 8'd3, 4'hC, 1'b0, -1, 2'd0, 2'd0, 2'd0, 1'b0);
        finish_cmd(1'b1);
        no_b = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
